cut_position_generator: RTL and testbench

CUT_POSITION_GENERATOR -- requirements
Module: cut_position_generator

---
 rtl/video_crypto_pkg.sv | 16 +
 rtl/lfsr32_step.sv | 9 +
 rtl/cut_position_generator.sv | 112 +++++++++++
 tb/tb_cut_position_generator.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_crypto_pkg.sv
// Shared constants and state encoding for the cut-position keystream generator.
package video_crypto_pkg;
    localparam int CUT_W  = 8;
    localparam int LINE_W = 10;
    localparam int SEED_W = 32;

    localparam logic [SEED_W-1:0] LFSR_POLY_DEFAULT  = 32'h80200003;
    localparam logic [SEED_W-1:0] DEFAULT_SEED_VALUE = 32'd42;
    localparam logic [LINE_W-1:0] LINE_MAX           = 10'd1023;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_RUN        = 2'd2
    } state_t;
endpackage

// File: rtl/lfsr32_step.sv
// One Galois LFSR advance in right-shift form: feedback applied when the lsb shifts out.
module lfsr32_step #(
    parameter logic [31:0] POLY = video_crypto_pkg::LFSR_POLY_DEFAULT
) (
    input  logic [31:0] i_state,
    output logic [31:0] o_state
);
    assign o_state = i_state[0] ? ((i_state >> 1) ^ POLY) : (i_state >> 1);
endmodule

// File: rtl/cut_position_generator.sv
// Keyed per-line cut positions: LFSR reloaded from the pending seed at each frame start,
// advanced once per active line.
//
// state         | meaning
// ST_IDLE       | out of reset, no seed yet, waiting for seed or frame start
// ST_WAIT_FRAME | seed accepted, waiting for the next frame start to load it
// ST_RUN        | generating, one cut_position per active line
module cut_position_generator #(
    parameter logic [video_crypto_pkg::SEED_W-1:0] LFSR_POLY    = video_crypto_pkg::LFSR_POLY_DEFAULT,
    parameter logic [video_crypto_pkg::SEED_W-1:0] DEFAULT_SEED = video_crypto_pkg::DEFAULT_SEED_VALUE
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  H,
    input  logic                                  V,
    input  logic                                  F,
    input  logic [video_crypto_pkg::SEED_W-1:0]   seed_in,
    input  logic                                  seed_valid,
    output logic                                  seed_ready,
    output logic [video_crypto_pkg::CUT_W-1:0]    cut_position,
    output logic                                  cut_valid,
    output logic [video_crypto_pkg::LINE_W-1:0]   line_index,
    output logic                                  locked
);
    import video_crypto_pkg::*;

    state_t              r_state;
    logic                r_h_q;
    logic                r_v_q;
    logic [SEED_W-1:0]   r_lfsr;
    logic [SEED_W-1:0]   r_pending_seed;
    logic [CUT_W-1:0]    r_cut_position;
    logic                r_cut_valid;
    logic [LINE_W-1:0]   r_line_index;

    logic                w_h_rise;
    logic                w_frame_start;
    logic                w_seed_accept;
    logic [SEED_W-1:0]   w_seed_value;
    logic [SEED_W-1:0]   w_load_seed;
    logic [SEED_W-1:0]   w_lfsr_next;

    assign w_h_rise      = H & ~r_h_q;
    assign w_frame_start = r_v_q & ~V & ~F;
    assign seed_ready    = ~reset;
    assign w_seed_accept = seed_valid & seed_ready;
    assign w_seed_value  = (seed_in == '0) ? DEFAULT_SEED : seed_in;
    // A seed offered on the frame-start cycle wins over the stored one.
    assign w_load_seed   = w_seed_accept ? w_seed_value : r_pending_seed;

    lfsr32_step #(
        .POLY (LFSR_POLY)
    ) u_step (
        .i_state (r_lfsr),
        .o_state (w_lfsr_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_h_q          <= 1'b0;
            r_v_q          <= 1'b0;
            r_lfsr         <= DEFAULT_SEED;
            r_pending_seed <= DEFAULT_SEED;
            r_cut_position <= '0;
            r_cut_valid    <= 1'b0;
            r_line_index   <= '0;
        end else begin
            r_h_q       <= H;
            r_v_q       <= V;
            r_cut_valid <= 1'b0;
            if (w_seed_accept) begin
                r_pending_seed <= w_seed_value;
            end
            // Frame start reloads and suppresses any coincident line step.
            if (w_frame_start) begin
                r_state      <= ST_RUN;
                r_lfsr       <= w_load_seed;
                r_line_index <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_seed_accept) begin
                            r_state <= ST_WAIT_FRAME;
                        end
                    end
                    ST_WAIT_FRAME: begin
                        r_state <= ST_WAIT_FRAME;
                    end
                    ST_RUN: begin
                        if (w_h_rise && !V) begin
                            r_lfsr         <= w_lfsr_next;
                            r_cut_position <= w_lfsr_next[CUT_W-1:0];
                            r_cut_valid    <= 1'b1;
                            if (r_line_index != LINE_MAX) begin
                                r_line_index <= r_line_index + 10'd1;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign cut_position = r_cut_position;
    assign cut_valid    = r_cut_valid;
    assign line_index   = r_line_index;
    assign locked       = (r_state == ST_RUN);
endmodule

// File: tb/tb_cut_position_generator.sv
// Directed bench for cut_position_generator with a queue-based cut_position scoreboard.
module tb_cut_position_generator;
    logic        clk = 1'b0;
    logic        reset;
    logic        H, V, F;
    logic [31:0] seed_in;
    logic        seed_valid;
    logic        seed_ready;
    logic [7:0]  cut_position;
    logic        cut_valid;
    logic [9:0]  line_index;
    logic        locked;

    int          checks   = 0;
    int          failures = 0;
    int          pops     = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] m_lfsr;

    cut_position_generator dut (
        .clk          (clk),
        .reset        (reset),
        .H            (H),
        .V            (V),
        .F            (F),
        .seed_in      (seed_in),
        .seed_valid   (seed_valid),
        .seed_ready   (seed_ready),
        .cut_position (cut_position),
        .cut_valid    (cut_valid),
        .line_index   (line_index),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 2 time units after the active edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_h(input bit expect_valid);
        int p0;
        p0 = pops;
        H = 1'b1;
        tick();
        H = 1'b0;
        tick();
        check("cut_valid_pulses", pops, p0 + (expect_valid ? 1 : 0));
    endtask

    task automatic line_hand(input logic [7:0] e);
        m_lfsr = ref_step(m_lfsr);
        exp_q.push_back(e);
        pulse_h(1'b1);
    endtask

    task automatic line_model();
        m_lfsr = ref_step(m_lfsr);
        exp_q.push_back(m_lfsr[7:0]);
        pulse_h(1'b1);
    endtask

    task automatic frame(input logic [31:0] seed_used);
        V = 1'b1;
        tick();
        V = 1'b0;
        tick();
        m_lfsr = seed_used;
    endtask

    task automatic offer_seed(input logic [31:0] s);
        seed_in    = s;
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Monitor: every cut_valid cycle must match the next queued expectation.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (cut_valid === 1'b1) begin
                pops++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_cut_valid got=%0h expected=none at %0t", cut_position, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("cut_position", int'(cut_position), int'(e));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; H = 1'b0; V = 1'b0; F = 1'b0;
        seed_in = '0; seed_valid = 1'b0; m_lfsr = 32'd42;
        tick();
        tick();
        check("rst_cut_position", int'(cut_position), 0);
        check("rst_cut_valid",    int'(cut_valid), 0);
        check("rst_line_index",   int'(line_index), 0);
        check("rst_locked",       int'(locked), 0);
        check("rst_seed_ready",   int'(seed_ready), 0);
        reset = 1'b0;
        tick();
        check("seed_ready_after_rst", int'(seed_ready), 1);
        pulse_h(1'b0);
        check("idle_cut_position", int'(cut_position), 0);

        // Seed 1: hand-computed keystream 03, 02, 01.
        offer_seed(32'h1);
        check("wait_frame_locked", int'(locked), 0);
        pulse_h(1'b0);
        frame(32'h1);
        check("run_locked", int'(locked), 1);
        check("frame_line_index", int'(line_index), 0);
        line_hand(8'h03);
        line_hand(8'h02);
        line_hand(8'h01);
        check("line_index_3", int'(line_index), 3);

        // Zero seed falls back to 42: hand-computed 15, 09.
        do_reset();
        offer_seed(32'h0);
        frame(32'd42);
        line_hand(8'h15);
        check("zero_seed_locked", int'(locked), 1);
        line_hand(8'h09);

        // No seed: IDLE goes straight to RUN on frame start; lines under V are ignored.
        do_reset();
        frame(32'd42);
        check("idle_to_run_locked", int'(locked), 1);
        V = 1'b1;
        for (int i = 0; i < 3; i++) pulse_h(1'b0);
        check("vblank_line_index", int'(line_index), 0);
        check("vblank_cut_position", int'(cut_position), 0);
        V = 1'b0;
        tick();
        m_lfsr = 32'd42;
        line_hand(8'h15);

        // Seed offered on the frame-start cycle from IDLE, then a repeat frame.
        do_reset();
        V = 1'b1;
        tick();
        V = 1'b0;
        seed_in = 32'h12345678;
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        m_lfsr = 32'h12345678;
        check("same_cycle_locked", int'(locked), 1);
        line_model();
        line_model();
        begin
            logic [7:0] last_cut;
            int p0;
            last_cut = m_lfsr[7:0];
            p0 = pops;
            // Frame start coincident with an H rise: reload only, no pulse.
            V = 1'b1;
            tick();
            V = 1'b0;
            H = 1'b1;
            tick();
            H = 1'b0;
            tick();
            check("frame_and_h_no_pulse", pops, p0);
            check("frame_keeps_cut", int'(cut_position), int'(last_cut));
            check("frame_and_h_line_index", int'(line_index), 0);
        end
        m_lfsr = 32'h12345678;
        line_model();
        line_model();

        // Line counter and saturation.
        frame(32'h12345678);
        for (int i = 0; i < 300; i++) line_model();
        check("line_index_300", int'(line_index), 300);
        for (int i = 0; i < 800; i++) line_model();
        check("line_index_sat", int'(line_index), 1023);

        // Asynchronous reset mid-frame discards the pending seed and sequence.
        frame(32'h12345678);
        line_model();
        offer_seed(32'h1);
        H = 1'b1;
        tick();
        reset = 1'b1;
        #1;
        check("async_cut_position", int'(cut_position), 0);
        check("async_cut_valid",    int'(cut_valid), 0);
        check("async_line_index",   int'(line_index), 0);
        check("async_locked",       int'(locked), 0);
        check("async_seed_ready",   int'(seed_ready), 0);
        H = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_locked", int'(locked), 0);
        frame(32'd42);
        line_hand(8'h15);

        tick();
        tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
